// File: rtl/mdio_responder.sv
// Clause-22 MDIO management responder (PHY side): oversamples MDC/MDIO, decodes frames, drives reads.
// Optional build macro MDIO_PREAMBLE_SUPPRESS_EN presets the preamble counter after each completed frame.
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'h01,
    parameter int unsigned PREAMBLE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oe,
    output logic [4:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_wr,
    input  logic [15:0] reg_rdata,
    output logic        busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ST1  = 3'd1;
    localparam logic [2:0] S_OP   = 3'd2;
    localparam logic [2:0] S_PHY  = 3'd3;
    localparam logic [2:0] S_REG  = 3'd4;
    localparam logic [2:0] S_TA   = 3'd5;
    localparam logic [2:0] S_DATA = 3'd6;
    localparam logic [2:0] S_SKIP = 3'd7;

    localparam logic [5:0] PRE_MAX = 6'd63;
    localparam logic [5:0] PRE_LEN = 6'(PREAMBLE_LEN);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam logic [5:0] DONE_PRE = PRE_LEN;
`else
    localparam logic [5:0] DONE_PRE = 6'd0;
`endif

    logic [2:0]  mdc_s_q;
    logic [1:0]  mdio_s_q;
    logic        rise;
    logic        fall;
    logic        bit_in;

    logic [2:0]  state_q, state_d;
    logic [4:0]  fcnt_q, fcnt_d;
    logic [5:0]  pre_q, pre_d;
    logic [14:0] sh_q, sh_d;
    logic        rd_q, rd_d;
    logic [15:0] rsh_q, rsh_d;
    logic        out_q, out_d;
    logic        oe_q, oe_d;
    logic [4:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdc_s_q  <= '0;
            mdio_s_q <= '0;
        end else begin
            mdc_s_q  <= {mdc_s_q[1:0], mdc};
            mdio_s_q <= {mdio_s_q[0], mdio_in};
        end
    end

    assign rise   = mdc_s_q[1] & ~mdc_s_q[2];
    assign fall   = ~mdc_s_q[1] & mdc_s_q[2];
    assign bit_in = mdio_s_q[1];

    // fcnt_q holds the index (ST0 = 0) of the next frame bit to be sampled; after
    // the last read bit it wraps to 0, which marks the final release fall.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        pre_d   = pre_q;
        sh_d    = sh_q;
        rd_d    = rd_q;
        rsh_d   = rsh_q;
        out_d   = out_q;
        oe_d    = oe_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = 1'b0;

        if (rise) begin
            fcnt_d = fcnt_q + 5'd1;
            sh_d   = {sh_q[13:0], bit_in};
            case (state_q)
                S_IDLE: begin
                    fcnt_d = 5'd1;
                    if (bit_in) begin
                        pre_d = (pre_q == PRE_MAX) ? PRE_MAX : pre_q + 6'd1;
                    end else begin
                        if (pre_q >= PRE_LEN) begin
                            state_d = S_ST1;
                        end
                        pre_d = '0;
                    end
                end
                S_ST1: begin
                    if (bit_in) begin
                        state_d = S_OP;
                    end else begin
                        state_d = S_IDLE;
                        pre_d   = '0;
                    end
                end
                S_OP: begin
                    if (fcnt_q == 5'd3) begin
                        case ({sh_q[0], bit_in})
                            2'b10: begin
                                rd_d    = 1'b1;
                                state_d = S_PHY;
                            end
                            2'b01: begin
                                rd_d    = 1'b0;
                                state_d = S_PHY;
                            end
                            default: state_d = S_SKIP;
                        endcase
                    end
                end
                S_PHY: begin
                    if (fcnt_q == 5'd8) begin
                        state_d = ({sh_q[3:0], bit_in} == PHY_ADDR) ? S_REG : S_SKIP;
                    end
                end
                S_REG: begin
                    if (fcnt_q == 5'd13) begin
                        addr_d  = {sh_q[3:0], bit_in};
                        state_d = S_TA;
                    end
                end
                S_TA: begin
                    if (fcnt_q == 5'd15) begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (!rd_q && fcnt_q == 5'd31) begin
                        wdata_d = {sh_q, bit_in};
                        wr_d    = 1'b1;
                        state_d = S_IDLE;
                        pre_d   = DONE_PRE;
                    end
                end
                S_SKIP: begin
                    if (fcnt_q == 5'd31) begin
                        state_d = S_IDLE;
                        pre_d   = '0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    pre_d   = '0;
                end
            endcase
        end else if (fall && rd_q) begin
            if (state_q == S_TA && fcnt_q == 5'd15) begin
                rsh_d = reg_rdata;
                oe_d  = 1'b1;
                out_d = 1'b0;
            end else if (state_q == S_DATA) begin
                if (fcnt_q == 5'd0) begin
                    oe_d    = 1'b0;
                    out_d   = 1'b0;
                    state_d = S_IDLE;
                    pre_d   = DONE_PRE;
                end else begin
                    out_d = rsh_q[15];
                    rsh_d = {rsh_q[14:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
            pre_q   <= '0;
            sh_q    <= '0;
            rd_q    <= 1'b0;
            rsh_q   <= '0;
            out_q   <= 1'b0;
            oe_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            pre_q   <= pre_d;
            sh_q    <= sh_d;
            rd_q    <= rd_d;
            rsh_q   <= rsh_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
        end
    end

    assign mdio_out  = out_q;
    assign mdio_oe   = oe_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_wr    = wr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mdio_responder.sv
// Directed frame-table bench for mdio_responder plus hand-written reset and bad-opcode sequences.
module tb_mdio_responder;

    localparam int unsigned HALF = 80;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam logic SUP = 1'b1;
`else
    localparam logic SUP = 1'b0;
`endif

    typedef struct {
        int unsigned pre;
        logic [1:0]  op;
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic [15:0] wdata;
        logic        exp_wr;
        logic        exp_rd;
        logic [4:0]  exp_addr;
        logic [15:0] exp_data;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        mdc;
    logic        mdio_drv;
    logic        mdio_line;
    logic        mdio_out;
    logic        mdio_oe;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_wr;
    logic [15:0] reg_rdata;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned wr_cnt   = 0;
    int unsigned oe_cnt   = 0;
    logic [4:0]  last_waddr = '0;
    logic [15:0] last_wdata = '0;

    vec_t vecs[14];

    // Open-drain style bus: the master releases (pull-up reads 1) while the responder drives.
    assign mdio_line = mdio_oe ? mdio_out : mdio_drv;

    always_comb begin
        case (reg_addr)
            5'd0:    reg_rdata = 16'h8001;
            5'd2:    reg_rdata = 16'h1234;
            5'd7:    reg_rdata = 16'hC3A5;
            default: reg_rdata = {reg_addr, reg_addr, reg_addr, 1'b0};
        endcase
    end

    mdio_responder #(
        .PHY_ADDR(5'h01),
        .PREAMBLE_LEN(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mdc(mdc),
        .mdio_in(mdio_line),
        .mdio_out(mdio_out),
        .mdio_oe(mdio_oe),
        .reg_addr(reg_addr),
        .reg_wdata(reg_wdata),
        .reg_wr(reg_wr),
        .reg_rdata(reg_rdata),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_wr) begin
            wr_cnt++;
            last_waddr = reg_addr;
            last_wdata = reg_wdata;
        end
        if (mdio_oe) oe_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic send_bit(input logic b, output logic line_s, output logic oe_s);
        mdc      = 1'b0;
        mdio_drv = b;
        #HALF;
        line_s = mdio_line;
        oe_s   = mdio_oe;
        mdc    = 1'b1;
        #HALF;
    endtask

    function automatic logic [31:0] frame_word(input vec_t v);
        if (v.op == 2'b10) return {2'b01, v.op, v.phy, v.regad, 2'b11, 16'hFFFF};
        return {2'b01, v.op, v.phy, v.regad, 2'b10, v.wdata};
    endfunction

    task automatic do_frame(input vec_t v, output logic [16:0] rsp, output logic [1:0] oe_ta);
        logic [31:0] fr;
        logic ls, os;
        fr    = frame_word(v);
        rsp   = '0;
        oe_ta = '0;
        for (int unsigned i = 0; i < v.pre; i++) send_bit(1'b1, ls, os);
        for (int i = 0; i < 32; i++) begin
            send_bit(fr[31-i], ls, os);
            if (i >= 15) rsp[31-i] = ls;
            if (i == 14) oe_ta[1] = os;
            if (i == 15) oe_ta[0] = os;
        end
        mdc      = 1'b0;
        mdio_drv = 1'b1;
        #HALF;
    endtask

    initial begin
        logic [16:0] rsp;
        logic [1:0]  oe_ta;
        logic [31:0] fr;
        logic        ls, os;
        int unsigned wr0, oe0;

        mdc      = 1'b0;
        mdio_drv = 1'b1;
        reset    = 1'b1;
        #23;
        check("rst_oe", {31'd0, mdio_oe}, 32'd0);
        check("rst_out", {31'd0, mdio_out}, 32'd0);
        check("rst_wr", {31'd0, reg_wr}, 32'd0);
        check("rst_addr", {27'd0, reg_addr}, 32'd0);
        check("rst_wdata", {16'd0, reg_wdata}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        #40;

        //         pre op     phy    reg    wdata     wr    rd    addr   data
        vecs[0]  = '{32, 2'b01, 5'd1,  5'd3,  16'hBEEF, 1'b1, 1'b0, 5'd3,  16'hBEEF};
        vecs[1]  = '{32, 2'b10, 5'd1,  5'd2,  16'h0000, 1'b0, 1'b1, 5'd2,  16'h1234};
        vecs[2]  = '{32, 2'b01, 5'd2,  5'd5,  16'h5555, 1'b0, 1'b0, 5'd0,  16'h0000};
        vecs[3]  = '{31, 2'b10, 5'd1,  5'd2,  16'h0000, 1'b0, 1'b0, 5'd0,  16'h0000};
        vecs[4]  = '{32, 2'b10, 5'd1,  5'd7,  16'h0000, 1'b0, 1'b1, 5'd7,  16'hC3A5};
        vecs[5]  = '{31, 2'b01, 5'd1,  5'd4,  16'h0F0F, SUP,  1'b0, 5'd4,  16'h0F0F};
        vecs[6]  = '{32, 2'b11, 5'd1,  5'd9,  16'hFFFF, 1'b0, 1'b0, 5'd0,  16'h0000};
        vecs[7]  = '{32, 2'b00, 5'd1,  5'd9,  16'h1111, 1'b0, 1'b0, 5'd0,  16'h0000};
        vecs[8]  = '{32, 2'b01, 5'd1,  5'd31, 16'h0001, 1'b1, 1'b0, 5'd31, 16'h0001};
        vecs[9]  = '{32, 2'b10, 5'd1,  5'd0,  16'h0000, 1'b0, 1'b1, 5'd0,  16'h8001};
        vecs[10] = '{32, 2'b01, 5'd0,  5'd1,  16'h7777, 1'b0, 1'b0, 5'd0,  16'h0000};
        vecs[11] = '{32, 2'b10, 5'd31, 5'd2,  16'h0000, 1'b0, 1'b0, 5'd0,  16'h0000};
        vecs[12] = '{32, 2'b01, 5'd1,  5'd6,  16'hA5A5, 1'b1, 1'b0, 5'd6,  16'hA5A5};
        vecs[13] = '{1,  2'b10, 5'd1,  5'd2,  16'h0000, 1'b0, SUP,  5'd2,  16'h1234};

        for (int v = 0; v < 14; v++) begin
            wr0 = wr_cnt;
            oe0 = oe_cnt;
            do_frame(vecs[v], rsp, oe_ta);
            check($sformatf("v%0d_wr_count", v), wr_cnt - wr0, {31'd0, vecs[v].exp_wr});
            if (vecs[v].exp_wr) begin
                check($sformatf("v%0d_wr_addr", v), {27'd0, last_waddr}, {27'd0, vecs[v].exp_addr});
                check($sformatf("v%0d_wr_data", v), {16'd0, last_wdata}, {16'd0, vecs[v].exp_data});
            end
            if (vecs[v].exp_rd) begin
                check($sformatf("v%0d_rd_data", v), {15'd0, rsp}, {15'd0, 1'b0, vecs[v].exp_data});
                check($sformatf("v%0d_oe_ta", v), {30'd0, oe_ta}, 32'd1);
                check($sformatf("v%0d_rd_addr", v), {27'd0, reg_addr}, {27'd0, vecs[v].exp_addr});
            end else begin
                check($sformatf("v%0d_oe_quiet", v), oe_cnt - oe0, 32'd0);
            end
            check($sformatf("v%0d_oe_end", v), {31'd0, mdio_oe}, 32'd0);
            check($sformatf("v%0d_busy_end", v), {31'd0, busy}, 32'd0);
        end

        // Bad opcode: busy from the ST0 sample through exactly 32 bit-times.
        oe0 = oe_cnt;
        for (int i = 0; i < 32; i++) send_bit(1'b1, ls, os);
        send_bit(1'b0, ls, os);
        check("skip_busy_st", {31'd0, busy}, 32'd1);
        for (int i = 1; i < 31; i++) send_bit((i < 4) ? 1'b1 : 1'b0, ls, os);
        check("skip_busy_b30", {31'd0, busy}, 32'd1);
        send_bit(1'b0, ls, os);
        check("skip_busy_end", {31'd0, busy}, 32'd0);
        check("skip_oe_quiet", oe_cnt - oe0, 32'd0);

        // Reset in the middle of the 8th read data bit.
        fr = {2'b01, 2'b10, 5'd1, 5'd7, 2'b11, 16'hFFFF};
        for (int i = 0; i < 32; i++) send_bit(1'b1, ls, os);
        for (int i = 0; i < 23; i++) send_bit(fr[31-i], ls, os);
        mdc      = 1'b0;
        mdio_drv = 1'b1;
        #(HALF/2);
        check("midrd_oe", {31'd0, mdio_oe}, 32'd1);
        reset = 1'b1;
        #1;
        check("midrd_rst_oe", {31'd0, mdio_oe}, 32'd0);
        check("midrd_rst_busy", {31'd0, busy}, 32'd0);
        #20;
        reset = 1'b0;
        #HALF;
        wr0 = wr_cnt;
        do_frame('{32, 2'b10, 5'd1, 5'd2, 16'h0000, 1'b0, 1'b1, 5'd2, 16'h1234}, rsp, oe_ta);
        check("post_rst_rd", {15'd0, rsp}, {15'd0, 17'h01234});
        check("post_rst_oe_ta", {30'd0, oe_ta}, 32'd1);
        check("post_rst_no_wr", wr_cnt - wr0, 32'd0);
        check("post_rst_oe_end", {31'd0, mdio_oe}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
